// File: rtl/bloonstd1_soc_pio_pkg.sv
// Shared constants for the bloonstd1 SoC parallel I/O slave:
// Avalon-MM register addresses and edge-type encodings.
package bloonstd1_soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/bloonstd1_soc_sync_bus.sv
// Multi-flop synchronizer for a bus of independent asynchronous bits.
module bloonstd1_soc_sync_bus #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/bloonstd1_soc_edge_pio.sv
// Edge-capturing parallel input port with Avalon-MM register access
// and a level interrupt from masked edge-capture bits.
module bloonstd1_soc_edge_pio
    import bloonstd1_soc_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int BIT_CLEAR   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [2:0]       settle_cnt;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             settled;
    logic             unused_wdata;

    bloonstd1_soc_sync_bus #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (data_sync)
    );

    assign wr           = chipselect & ~write_n;
    assign settled      = (settle_cnt == SETTLE_MAX);
    assign unused_wdata = &{1'b0, writedata};

    generate
        if (EDGE_TYPE == EDGE_RISING) begin : g_rise
            assign edge_raw = data_sync & ~prev;
        end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_raw = ~data_sync & prev;
        end else begin : g_any
            assign edge_raw = data_sync ^ prev;
        end
    endgenerate

    // Suppress edges until the synchronizer and prev hold real input data.
    assign edge_ev = settled ? edge_raw : '0;

    always_comb begin
        clr_mask = '0;
        if (wr && (address == ADDR_EDGECAP)) begin
            clr_mask = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = 32'(data_sync);
            ADDR_IRQMASK: rd_mux = 32'(irqmask);
            ADDR_EDGECAP: rd_mux = 32'(edgecap);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev       <= '0;
            settle_cnt <= '0;
            irqmask    <= '0;
            edgecap    <= '0;
            readdata   <= '0;
        end else begin
            prev <= data_sync;
            if (!settled) begin
                settle_cnt <= settle_cnt + 3'd1;
            end
            if (wr && (address == ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // New edges win over a simultaneous clear so no event is lost.
            edgecap  <= (edgecap & ~clr_mask) | edge_ev;
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_bloonstd1_soc_edge_pio.sv
// Directed bench: three PIO instances (rising/bit-clear, any-edge, falling/clear-all)
// exercised through their Avalon-MM ports with hand-computed expectations.
module tb_bloonstd1_soc_edge_pio;
    import bloonstd1_soc_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n    [3];
    logic [1:0]  address    [3];
    logic        chipselect [3];
    logic        write_n    [3];
    logic [31:0] writedata  [3];
    logic [7:0]  in_port    [3];
    logic [31:0] readdata   [3];
    logic        irq        [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bloonstd1_soc_edge_pio #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2), .BIT_CLEAR(1)) dut_rise (
        .clk(clk), .reset_n(reset_n[0]), .address(address[0]), .chipselect(chipselect[0]),
        .write_n(write_n[0]), .writedata(writedata[0]), .in_port(in_port[0]),
        .readdata(readdata[0]), .irq(irq[0])
    );

    bloonstd1_soc_edge_pio #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2), .BIT_CLEAR(1)) dut_any (
        .clk(clk), .reset_n(reset_n[1]), .address(address[1]), .chipselect(chipselect[1]),
        .write_n(write_n[1]), .writedata(writedata[1]), .in_port(in_port[1]),
        .readdata(readdata[1]), .irq(irq[1])
    );

    bloonstd1_soc_edge_pio #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(2), .BIT_CLEAR(0)) dut_fall (
        .clk(clk), .reset_n(reset_n[2]), .address(address[2]), .chipselect(chipselect[2]),
        .write_n(write_n[2]), .writedata(writedata[2]), .in_port(in_port[2]),
        .readdata(readdata[2]), .irq(irq[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One-cycle bus write starting at the current negedge; returns on the next negedge.
    task automatic applyStimulus(input int idx, input logic [1:0] addr, input logic [31:0] data);
        address[idx]    = addr;
        writedata[idx]  = data;
        chipselect[idx] = 1'b1;
        write_n[idx]    = 1'b0;
        @(negedge clk);
        chipselect[idx] = 1'b0;
        write_n[idx]    = 1'b1;
        writedata[idx]  = '0;
    endtask

    task automatic read_reg(input int idx, input logic [1:0] addr, output logic [31:0] value);
        address[idx] = addr;
        @(negedge clk);
        value = readdata[idx];
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed no finish, expected finish before 100us");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] v;

        for (int i = 0; i < 3; i++) begin
            reset_n[i]    = 1'b0;
            address[i]    = ADDR_DATA;
            chipselect[i] = 1'b0;
            write_n[i]    = 1'b1;
            writedata[i]  = '0;
        end
        in_port[0] = 8'h00;
        in_port[1] = 8'hFF;
        in_port[2] = 8'hFF;

        wait_cycles(3);
        checkOutput("reset_readdata_rise", readdata[0], 32'h0);
        checkOutput("reset_readdata_any", readdata[1], 32'h0);
        checkOutput("reset_irq_rise", 32'(irq[0]), 32'h0);
        for (int i = 0; i < 3; i++) reset_n[i] = 1'b1;

        // Any-edge instance: input high through reset release must capture nothing.
        for (int c = 0; c < 20; c++) begin
            read_reg(1, ADDR_EDGECAP, v);
            checkOutput("any_static_high_edgecap", v, 32'h0);
        end
        read_reg(1, ADDR_DATA, v);
        checkOutput("any_data", v, 32'hFF);
        in_port[1] = 8'hF7;
        wait_cycles(4);
        read_reg(1, ADDR_EDGECAP, v);
        checkOutput("any_fall_captured", v, 32'h08);
        in_port[1] = 8'hFF;
        wait_cycles(4);
        read_reg(1, ADDR_EDGECAP, v);
        checkOutput("any_sticky", v, 32'h08);

        // Rising instance: data latency and basic capture.
        read_reg(0, ADDR_EDGECAP, v);
        checkOutput("rise_edgecap_idle", v, 32'h0);
        read_reg(0, ADDR_DATA, v);
        checkOutput("rise_data_idle", v, 32'h0);
        in_port[0] = 8'h05;
        wait_cycles(2);
        checkOutput("rise_data_latency_2", readdata[0], 32'h00);
        wait_cycles(1);
        checkOutput("rise_data_latency_3", readdata[0], 32'h05);
        read_reg(0, ADDR_EDGECAP, v);
        checkOutput("rise_edgecap_05", v, 32'h05);
        checkOutput("rise_irq_masked", 32'(irq[0]), 32'h0);

        applyStimulus(0, ADDR_EDGECAP, 32'h01);
        read_reg(0, ADDR_EDGECAP, v);
        checkOutput("rise_partial_clear", v, 32'h04);
        applyStimulus(0, ADDR_EDGECAP, 32'h04);
        read_reg(0, ADDR_EDGECAP, v);
        checkOutput("rise_full_clear", v, 32'h00);

        applyStimulus(0, ADDR_IRQMASK, 32'hFFFF_FF04);
        read_reg(0, ADDR_IRQMASK, v);
        checkOutput("rise_irqmask", v, 32'h04);
        in_port[0] = 8'h01;
        wait_cycles(4);
        checkOutput("rise_ignores_fall_irq", 32'(irq[0]), 32'h0);
        read_reg(0, ADDR_EDGECAP, v);
        checkOutput("rise_ignores_fall", v, 32'h00);
        in_port[0] = 8'h05;
        wait_cycles(4);
        checkOutput("rise_irq_set", 32'(irq[0]), 32'h1);
        applyStimulus(0, ADDR_EDGECAP, 32'h04);
        checkOutput("rise_irq_cleared", 32'(irq[0]), 32'h0);
        read_reg(0, ADDR_EDGECAP, v);
        checkOutput("rise_edgecap_after_clear", v, 32'h00);

        // Edge on bit1 lands on the same clock as its clear.
        in_port[0] = 8'h07;
        wait_cycles(2);
        applyStimulus(0, ADDR_EDGECAP, 32'h02);
        read_reg(0, ADDR_EDGECAP, v);
        checkOutput("rise_edge_beats_clear", v, 32'h02);

        applyStimulus(0, ADDR_DATA, 32'hFF);
        read_reg(0, ADDR_DATA, v);
        checkOutput("rise_data_write_ignored", v, 32'h07);
        read_reg(0, ADDR_IRQMASK, v);
        checkOutput("rise_irqmask_kept", v, 32'h04);
        read_reg(0, ADDR_RSVD, v);
        checkOutput("rise_rsvd_zero", v, 32'h0);

        // Falling instance with clear-all semantics.
        in_port[2] = 8'h7E;
        wait_cycles(4);
        read_reg(2, ADDR_EDGECAP, v);
        checkOutput("fall_edgecap_81", v, 32'h81);
        applyStimulus(2, ADDR_EDGECAP, 32'h00);
        read_reg(2, ADDR_EDGECAP, v);
        checkOutput("fall_clear_all", v, 32'h00);
        applyStimulus(2, ADDR_RSVD, 32'hFFFF_FFFF);
        read_reg(2, ADDR_RSVD, v);
        checkOutput("fall_rsvd_zero", v, 32'h0);

        applyStimulus(2, ADDR_IRQMASK, 32'hFF);
        in_port[2] = 8'h7F;
        wait_cycles(4);
        read_reg(2, ADDR_EDGECAP, v);
        checkOutput("fall_ignores_rise", v, 32'h00);
        in_port[2] = 8'h7E;
        wait_cycles(4);
        checkOutput("fall_irq_set", 32'(irq[2]), 32'h1);
        read_reg(2, ADDR_EDGECAP, v);
        checkOutput("fall_edgecap_01", v, 32'h01);

        // Mid-operation reset discards the pending edge and the mask.
        reset_n[2] = 1'b0;
        #1;
        checkOutput("fall_reset_irq", 32'(irq[2]), 32'h0);
        checkOutput("fall_reset_readdata", readdata[2], 32'h0);
        @(negedge clk);
        reset_n[2] = 1'b1;
        read_reg(2, ADDR_EDGECAP, v);
        checkOutput("fall_post_reset_edgecap", v, 32'h00);
        read_reg(2, ADDR_IRQMASK, v);
        checkOutput("fall_post_reset_irqmask", v, 32'h00);
        wait_cycles(4);
        read_reg(2, ADDR_EDGECAP, v);
        checkOutput("fall_post_reset_settled", v, 32'h00);
        read_reg(2, ADDR_DATA, v);
        checkOutput("fall_post_reset_data", v, 32'h7E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
